oam_dma_engine: RTL
===================

Name: oam_dma_engine

Overview:
- Sprite DMA engine for the 2A03 CPU's $4014 register; sits directly downstream of the CPU bus.
- Detects a CPU write to $4014 and stalls the CPU.
- Takes over the address/data bus and copies 256 bytes from page $XX00–$XXFF to the PPU OAM data port ($2004).
- Its dma_* outputs feed the top-level bus mux in front of the shared memory and PPU.

Parameters:
DMA_REG_ADDR, 16'h4014, CPU write address that triggers a transfer
OAM_DATA_ADDR, 16'h2004, destination address of every DMA write cycle
XFER_LEN, 256, bytes per transfer (8-bit index, must be 256 or less)

Ports:
clock  in  1  system clock, one CPU cycle per posedge
reset  in  1  synchronous, active-high reset
cpu_addr  in  16  CPU address bus
cpu_wdata  in  8  CPU write data
cpu_rw  in  1  CPU read/write (1 = read, 0 = write)
bus_rdata  in  8  memory read data, valid at the posedge ending a DMA read cycle
halt  out  1  stall request to CPU RDY; CPU holds state while high
dma_active  out  1  bus mux select; 1 = dma_* drives the bus
dma_addr  out  16  DMA address
dma_rw  out  1  DMA read/write
dma_wdata  out  8  DMA write data (latched byte)

Behaviour:
- Reset, taking effect at the posedge where reset=1:
  - halt=0, dma_active=0, dma_addr=0, dma_rw=1, dma_wdata=0.
  - state=IDLE, index=0, page=0, parity=0.
- parity flop toggles every clock when not in reset. parity=0 marks a "get" cycle, parity=1 a "put" cycle.
- States: IDLE, HALT_WAIT, ALIGN, READ, WRITE.
- IDLE:
  - On a posedge with cpu_rw=0 and cpu_addr==DMA_REG_ADDR: page<=cpu_wdata, halt<=1, go HALT_WAIT.
  - Triggers arriving while not in IDLE are ignored; the CPU is stalled then anyway.
- HALT_WAIT:
  - The CPU only honours RDY on read cycles, so stay here while cpu_rw=0 (e.g. back-to-back writes).
  - The first posedge with cpu_rw=1 counts as the halt cycle; the CPU is frozen from that point.
  - Next state is READ if the parity value for the next cycle is 0, else ALIGN.
  - dma_active rises with the first ALIGN/READ cycle.
- ALIGN: exactly one dummy cycle. dma_addr=OAM_DATA_ADDR, dma_rw=1 (harmless read). Go READ.
- READ (always a parity-0 cycle):
  - dma_addr={page, index}, dma_rw=1.
  - At the closing posedge, latch dma_wdata<=bus_rdata. Go WRITE.
- WRITE:
  - dma_addr=OAM_DATA_ADDR, dma_rw=0, dma_wdata stable for the whole cycle.
  - At the closing posedge: if index==XFER_LEN-1, clear halt and dma_active, set index=0, dma_rw=1, go IDLE; else index<=index+1, go READ.
- Stolen cycles per transfer, counted from the halt cycle through the last WRITE inclusive:
  - 513 when no ALIGN cycle is needed.
  - 514 when an ALIGN cycle is inserted.
  - halt drops at the end of the last WRITE; the CPU resumes on the next cycle.
- index is 8-bit and wraps only via the terminal check. Page $FF transfers read $FF00–$FFFF with no carry into the upper byte.
- dma_active=1 only in ALIGN/READ/WRITE. halt=1 in HALT_WAIT/ALIGN/READ/WRITE.
- Reset mid-transfer: returns to IDLE next clock with all outputs at reset values. No partial completion.
- A trigger coincident with reset: reset wins.
- A write to any other address, or a read of $4014, causes no action.

Test Plan:
- Load $0300–$03FF with value (addr & $FF) ^ $5A; CPU writes $03 to $4014 on a parity-0-next cycle, followed by a read. Expect: no ALIGN; exactly 256 reads $0300..$03FF alternating with writes to $2004 carrying $5A,$5B,…; halt high 513 cycles.
- Same transfer triggered one cycle later (opposite parity). Expect: one ALIGN cycle with dma_rw=1 at $2004; halt high 514 cycles; data sequence identical.
- CPU issues write $4014 then two more writes before a read. Expect: halt high but dma_active=0 through both writes; the DMA starts only after the first cpu_rw=1 cycle.
- Page $FF: expect last read address $FFFF, then halt=0 and state IDLE; no access to $0000.
- reset pulsed at index $80 during a WRITE. Expect: next cycle halt=0, dma_active=0, dma_rw=1, dma_addr=0; a fresh $4014 write restarts the transfer from index 0.
- CPU read of $4014 and write to $4015. Expect: halt stays 0 and dma_active stays 0 throughout.

Source files
------------

// File: rtl/oam_dma_engine.sv
// oam_dma_engine: sprite DMA behind the 2A03 $4014 register.
// A CPU write to DMA_REG_ADDR latches the source page and stalls the CPU.
// The engine then copies XFER_LEN bytes from {page, index} to the PPU OAM
// data port as alternating get (read) and put (write) bus cycles.
module oam_dma_engine #(
  parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
  parameter int          XFER_LEN      = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_rw,
  input  logic [7:0]  bus_rdata,
  output logic        halt,
  output logic        dma_active,
  output logic [15:0] dma_addr,
  output logic        dma_rw,
  output logic [7:0]  dma_wdata
);

  localparam logic [7:0] LAST_INDEX = 8'(XFER_LEN - 1);

  typedef enum logic [2:0] {
    IDLE,
    HALT_WAIT,
    ALIGN,
    READ,
    WRITE
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] index_q, index_d;
  logic [7:0] page_q,  page_d;
  logic       parity_q;
  logic [7:0] wdata_q;

  // State register, get/put parity and the byte carried from READ to WRITE.
  always_ff @(posedge clock) begin
    // NOTE: every flop here uses <= so all of them sample the pre-edge
    // values together; a blocking = would let later lines see new values.
    if (reset) begin
      state_q  <= IDLE;
      index_q  <= '0;
      page_q   <= '0;
      parity_q <= 1'b0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      index_q  <= index_d;
      page_q   <= page_d;
      parity_q <= ~parity_q;
      if (state_q == READ) wdata_q <= bus_rdata;
    end
  end

  // Next-state logic and the bus signals presented during each state.
  always_comb begin
    // NOTE: every output and next value gets a default before the case so
    // that no path leaves one unassigned, which would infer a latch.
    state_d    = state_q;
    index_d    = index_q;
    page_d     = page_q;
    halt       = 1'b1;
    dma_active = 1'b0;
    dma_addr   = '0;
    dma_rw     = 1'b1;

    unique case (state_q)
      IDLE: begin
        halt = 1'b0;
        if (!cpu_rw && cpu_addr == DMA_REG_ADDR) begin
          page_d  = cpu_wdata;
          state_d = HALT_WAIT;
        end
      end

      // RDY only stops the CPU on a read; a read cycle here is the halt
      // cycle. The first DMA cycle must be a get, so insert one dummy
      // cycle when the next cycle would be a put.
      HALT_WAIT: begin
        if (cpu_rw) state_d = parity_q ? READ : ALIGN;
      end

      ALIGN: begin
        dma_active = 1'b1;
        dma_addr   = OAM_DATA_ADDR;
        state_d    = READ;
      end

      READ: begin
        dma_active = 1'b1;
        dma_addr   = {page_q, index_q};
        state_d    = WRITE;
      end

      WRITE: begin
        dma_active = 1'b1;
        dma_addr   = OAM_DATA_ADDR;
        dma_rw     = 1'b0;
        if (index_q == LAST_INDEX) begin
          index_d = '0;
          state_d = IDLE;
        end else begin
          index_d = index_q + 8'd1;
          state_d = READ;
        end
      end

      default: begin
        halt    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign dma_wdata = wdata_q;

endmodule
